// File: rtl/regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : regfile                                                       |
// | Function : NPC integer register file (NREG x XLEN, x0 hard-wired to 0),  |
// |            retired-instruction counter and RUN/HALT controller that      |
// |            latches the halt state when an ebreak commits.                |
// | Option   : RF_BYPASS_EN - when defined, a read port whose address        |
// |            matches an accepted write returns wr_data in the same cycle.  |
// |            When undefined, reads return stored contents only.            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module regfile #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            commit,
  input  logic            ebreak,
  output logic            halted,
  output logic [63:0]     instret,
  output logic [XLEN-1:0] a0_data
);

  // Architectural register holding the simulator exit code.
  localparam logic [AW-1:0] A0_IDX = AW'(10);

  // Core run state. HALT is sticky until reset.
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [63:0]     instret_q;
  logic [63:0]     instret_d;

  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];

  // A write is accepted only while running and never for x0.
  logic            wr_fire;
  logic            retire;

  // Next-state, retire counting and halt detection.
  always_comb begin
    state_d   = state_q;
    instret_d = instret_q;
    retire    = 1'b0;
    if (state_q == ST_RUN && commit) begin
      retire    = 1'b1;
      // The ebreak itself is counted as a retired instruction.
      instret_d = instret_q + 64'd1;
      if (ebreak) begin
        state_d = ST_HALT;
      end
    end
  end

  // Register-file next values; the ebreak-cycle write still lands because
  // acceptance depends on the current (pre-halt) state.
  always_comb begin
    wr_fire = wr_en && (state_q == ST_RUN) && (wr_addr != '0);
    for (int i = 0; i < NREG; i++) begin
      rf_d[i] = rf_q[i];
    end
    if (wr_fire) begin
      rf_d[wr_addr] = wr_data;
    end
    rf_d[0] = '0;
  end

  // State, counter and register storage; reset overrides everything.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_RUN;
      instret_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

`ifdef RF_BYPASS_EN
  // Combinational read ports with same-cycle forwarding of an accepted write.
  always_comb begin
    rs1_data = (rs1_addr == '0) ? '0 : rf_q[rs1_addr];
    rs2_data = (rs2_addr == '0) ? '0 : rf_q[rs2_addr];
    if (wr_fire && (rs1_addr == wr_addr)) begin
      rs1_data = wr_data;
    end
    if (wr_fire && (rs2_addr == wr_addr)) begin
      rs2_data = wr_data;
    end
  end
`else
  // Combinational read ports returning stored contents only.
  always_comb begin
    rs1_data = (rs1_addr == '0) ? '0 : rf_q[rs1_addr];
    rs2_data = (rs2_addr == '0) ? '0 : rf_q[rs2_addr];
  end
`endif

  // Status outputs; a0 is the stored value, never forwarded.
  always_comb begin
    halted  = (state_q == ST_HALT);
    instret = instret_q;
    a0_data = rf_q[A0_IDX];
  end

endmodule
`default_nettype wire
